// File: rtl/add_circuit_2.sv
// Registered unsigned adder with carry-out: a ripple chain of full-adder cells
// feeds a result register that loads only when in_valid is high.

module add_circuit_2_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module add_circuit_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] z_d;
  logic             cout_d;
  logic [WIDTH-1:0] z_q;
  logic             cout_q;
  logic             out_valid_q;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      add_circuit_2_fa u_fa (
        .a_i (x[gi]),
        .b_i (y[gi]),
        .c_i (carry[gi]),
        .s_o (z_d[gi]),
        .c_o (carry[gi+1])
      );
    end
  endgenerate

  assign cout_d = carry[WIDTH];

  // The result register holds its value across idle cycles, so undriven
  // operands never reach z/cout while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        z_q    <= z_d;
        cout_q <= cout_d;
      end
    end
  end

  assign z         = z_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_circuit_2.sv
// Self-checking bench for add_circuit_2: directed vector table, async reset
// sequences and a random sweep on 8-bit and 16-bit instances.

module tb_add_circuit_2;

  logic        clk;
  logic        rst_n;
  logic        v8, v16;
  logic [7:0]  x8, y8;
  logic [15:0] x16, y16;
  logic [7:0]  z8;
  logic [15:0] z16;
  logic        c8, c16, ov8, ov16;

  int checks;
  int failures;

  // Reference state: last accepted result and the valid flag per instance
  int unsigned m8_z, m8_c, m8_v;
  int unsigned m16_z, m16_c, m16_v;

  add_circuit_2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8),
    .z(z8), .cout(c8), .out_valid(ov8)
  );

  add_circuit_2 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .x(x16), .y(y16),
    .z(z16), .cout(c16), .out_valid(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] ez;
    logic       ec;
    logic       ev;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " z8"},    64'(z8),   64'(m8_z));
    check({tag, " c8"},    64'(c8),   64'(m8_c));
    check({tag, " ov8"},   64'(ov8),  64'(m8_v));
    check({tag, " z16"},   64'(z16),  64'(m16_z));
    check({tag, " c16"},   64'(c16),  64'(m16_c));
    check({tag, " ov16"},  64'(ov16), 64'(m16_v));
  endtask

  task automatic model_reset();
    m8_z = 0;  m8_c = 0;  m8_v = 0;
    m16_z = 0; m16_c = 0; m16_v = 0;
  endtask

  // Drive one cycle of inputs, advance one rising edge, update the model, compare.
  task automatic step(input string tag,
                      input logic a_v8, input logic [7:0] a_x8, input logic [7:0] a_y8,
                      input logic a_v16, input logic [15:0] a_x16, input logic [15:0] a_y16);
    int unsigned s;
    v8 = a_v8;   x8 = a_x8;   y8 = a_y8;
    v16 = a_v16; x16 = a_x16; y16 = a_y16;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      m8_v = a_v8 ? 1 : 0;
      if (a_v8) begin
        s = int'(a_x8) + int'(a_y8);
        m8_z = s % 256;
        m8_c = (s >= 256) ? 1 : 0;
      end
      m16_v = a_v16 ? 1 : 0;
      if (a_v16) begin
        s = int'(a_x16) + int'(a_y16);
        m16_z = s % 65536;
        m16_c = (s >= 65536) ? 1 : 0;
      end
    end
    check_all(tag);
    $display("txn %s v=%0b x=%0d y=%0d -> z=%0d cout=%0b ov=%0b | v16=%0b x16=%0d y16=%0d -> z16=%0d cout16=%0b ov16=%0b",
             tag, a_v8, a_x8, a_y8, z8, c8, ov8, a_v16, a_x16, a_y16, z16, c16, ov16);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    v8 = 1'b0; x8 = '0; y8 = '0;
    v16 = 1'b0; x16 = '0; y16 = '0;

    vecs[0] = '{1'b1, 8'd2,   8'd2,   8'd4,   1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'd2,   8'd2,   8'd4,   1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'd255, 8'd255, 8'd254, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'd255, 8'd1,   8'd0,   1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'd2,   8'd2,   8'd4,   1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'd255, 8'd255, 8'd254, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'd100, 8'd27,  8'd127, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'd0,   8'd0,   8'd127, 1'b0, 1'b0};

    // Reset held with valid operands present: outputs stay cleared
    for (int i = 0; i < 4; i++)
      step("reset_hold", 1'b1, 8'd7, 8'd9, 1'b1, 16'd7, 16'd9);
    check("reset z8 literal", 64'(z8), 64'd0);
    rst_n = 1'b1;
    step("reset_release", 1'b1, 8'd7, 8'd9, 1'b1, 16'd7, 16'd9);
    check("release z8 literal", 64'(z8), 64'd16);
    check("release c8 literal", 64'(c8), 64'd0);

    // Directed vector table, checked against both the table and the model
    for (int i = 0; i < 10; i++) begin
      step("vec", vecs[i].v, vecs[i].x, vecs[i].y,
           vecs[i].v, 16'(vecs[i].x), 16'(vecs[i].y));
      check($sformatf("vec%0d z", i),  64'(z8),  64'(vecs[i].ez));
      check($sformatf("vec%0d c", i),  64'(c8),  64'(vecs[i].ec));
      check($sformatf("vec%0d ov", i), 64'(ov8), 64'(vecs[i].ev));
    end

    // 16-bit boundaries
    step("max16", 1'b0, 8'd0, 8'd0, 1'b1, 16'hFFFF, 16'hFFFF);
    check("max16 z literal", 64'(z16), 64'hFFFE);
    step("prop16", 1'b0, 8'd0, 8'd0, 1'b1, 16'hFFFF, 16'd1);
    check("prop16 z literal", 64'(z16), 64'h0);
    check("prop16 c literal", 64'(c16), 64'h1);

    // Async reset between edges with a transaction in flight
    step("pre_rst", 1'b1, 8'd200, 8'd100, 1'b1, 16'd60000, 16'd6000);
    v8 = 1'b1; x8 = 8'd200; y8 = 8'd100;
    v16 = 1'b1; x16 = 16'd60000; y16 = 16'd6000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    $display("txn async_rst z=%0d cout=%0b ov=%0b z16=%0d cout16=%0b ov16=%0b",
             z8, c8, ov8, z16, c16, ov16);
    step("rst_low", 1'b1, 8'd200, 8'd100, 1'b1, 16'd60000, 16'd6000);
    rst_n = 1'b1;
    step("post_rst_idle", 1'b0, 8'd200, 8'd100, 1'b0, 16'd60000, 16'd6000);
    step("post_rst_idle", 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 16'd0);

    // Random sweep, including X operands while idle
    for (int i = 0; i < 1000; i++) begin
      logic rv8, rv16;
      logic [7:0] rx8, ry8;
      logic [15:0] rx16, ry16;
      rv8  = 1'($urandom_range(0, 1));
      rv16 = 1'($urandom_range(0, 1));
      rx8  = 8'($urandom);
      ry8  = 8'($urandom);
      rx16 = 16'($urandom);
      ry16 = 16'($urandom);
      if (!rv8 && (i % 7 == 0)) begin
        rx8 = 'x; ry8 = 'x;
      end
      if (!rv16 && (i % 5 == 0)) begin
        rx16 = 'x; ry16 = 'x;
      end
      step("rand", rv8, rx8, ry8, rv16, rx16, ry16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_circuit_2.md
Name: add_circuit_2

Overview:
- Registered unsigned adder: sums two WIDTH-bit operands and produces a WIDTH-bit sum plus a carry-out.
- Used as a basic arithmetic leaf block wherever a registered add with carry-out is needed; the default is 8-bit.
- One clock domain; operands are sampled under a valid qualifier and results appear one cycle later with an output valid.

Parameters:
- WIDTH, 8, operand and sum bit width (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  when high, x/y are sampled on this clk edge.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- z  output  WIDTH  registered sum, low WIDTH bits of x+y.
- cout  output  1  registered carry-out, bit WIDTH of x+y.
- out_valid  output  1  high for one cycle when z/cout hold a newly computed result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset:
  - rst_n low forces z=0, cout=0 and out_valid=0 immediately, independent of clk.
  - The reset is held for as long as rst_n stays low.
  - On release, the block samples normally from the first rising clk edge with rst_n high.
- Arithmetic:
  - {cout, z} = x + y, computed at WIDTH+1 bits.
  - Unsigned; no carry-in; no saturation. Wrap-around is expressed only through cout.
  - Sum logic is a ripple chain of full-adder cells: bit i takes x[i], y[i] and carry c[i], with c[0]=0 and cout=c[WIDTH]. Implement it as a generate loop over a per-bit full-adder cell, not with a single "+" operator.
  - The chain is purely combinational between the input sampling point and the result register.
- Timing:
  - Latency is exactly 1 cycle. With in_valid=1 at rising edge N, z/cout reflect the sum of x/y sampled at edge N, and out_valid=1 after edge N.
  - Full throughput: back-to-back in_valid cycles each produce a result on consecutive cycles.
  - When in_valid=0 at an edge: z/cout hold their previous values and out_valid=0 for that cycle.
  - out_valid is a registered copy of in_valid, cleared by reset.
- Boundary conditions:
  - x=y=0 gives z=0, cout=0.
  - x=y=2^WIDTH-1 gives z=2^WIDTH-2, cout=1.
  - x=2^WIDTH-1, y=1 gives z=0, cout=1 (full carry propagation through every bit).
- Reset mid-operation: rst_n asserted while in_valid=1 gives z=0, cout=0, out_valid=0 immediately. The in-flight result is discarded and not produced after reset release.
- X-safety: z/cout are not updated from x/y unless in_valid=1, so undriven operands with in_valid=0 do not disturb the outputs.

Test Plan:
- Reset check: hold rst_n=0 for several cycles with in_valid=1, x=8'd7, y=8'd9 -> z=0, cout=0, out_valid=0 throughout. Deassert rst_n -> first result z=16, cout=0 one edge later.
- Small add: in_valid=1, x=2, y=2 for one edge -> next cycle z=4, cout=0, out_valid=1. Drop in_valid -> z holds 4, out_valid=0.
- Max overflow: x=255, y=255 -> z=254, cout=1. Then x=255, y=1 -> z=0, cout=1. Then x=0, y=0 -> z=0, cout=0.
- Back-to-back throughput: in_valid high for 4 edges with (2,2), (255,255), (128,128), (100,27) -> on consecutive cycles (z,cout) = (4,0), (254,1), (0,1), (127,0), with out_valid high on all 4.
- Async reset mid-stream: assert rst_n low between clock edges while in_valid=1, x=200, y=100 -> z, cout and out_valid go to 0 before the next edge. No result for that operand pair appears after release.
- Randomized sweep: 1000 random x/y pairs with random in_valid -> each valid result equals (x+y) mod 256 with cout=((x+y)>=256), checked against a model at 1-cycle latency. Repeat with WIDTH=16.
